// File: rtl/dlsc_mt9v032_pkg.sv
// Shared definitions for the MT9V032 multi-camera frame aligner.
package dlsc_mt9v032_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SYNC = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

    // LSB of camera lane 'lane' in a packed multi-camera pixel bus
    function automatic int unsigned lane_lsb(input int unsigned lane, input int unsigned width);
        return lane * width;
    endfunction

    // Position counter width; stays at least 1 bit for a degenerate 1-entry range
    function automatic int unsigned cnt_width(input int unsigned range);
        return (range > 1) ? $clog2(range) : 1;
    endfunction

endpackage

// File: rtl/dlsc_mt9v032_aligner_if.sv
// Pixel-stream bus between per-camera FIFOs, the aligner and the downstream pipeline.
interface dlsc_mt9v032_aligner_if #(
    parameter int unsigned CAMERAS = 2,
    parameter int unsigned DATA    = 10
);
    logic [CAMERAS-1:0]      in_ready;
    logic [CAMERAS-1:0]      in_valid;
    logic [CAMERAS-1:0]      in_sof;
    logic [CAMERAS*DATA-1:0] in_data;
    logic                    out_ready;
    logic                    out_valid;
    logic [CAMERAS*DATA-1:0] out_data;
    logic                    out_sof;
    logic                    out_eol;
    logic                    out_eof;

    // Camera FIFOs plus downstream consumer
    modport master (
        input  in_ready,
        output in_valid, in_sof, in_data,
        output out_ready,
        input  out_valid, out_data, out_sof, out_eol, out_eof
    );

    // The aligner itself
    modport slave (
        output in_ready,
        input  in_valid, in_sof, in_data,
        input  out_ready,
        output out_valid, out_data, out_sof, out_eol, out_eof
    );
endinterface

// File: rtl/dlsc_mt9v032_aligner_pos.sv
// Pixel position tracker: x/y counters with first-pixel / end-of-line / end-of-frame decode.
module dlsc_mt9v032_aligner_pos
    import dlsc_mt9v032_pkg::*;
#(
    parameter int unsigned HDISP = 752,
    parameter int unsigned VDISP = 480
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic adv,
    output logic at_origin,
    output logic at_eol,
    output logic at_eof
);
    localparam int unsigned   XW    = cnt_width(HDISP);
    localparam int unsigned   YW    = cnt_width(VDISP);
    localparam logic [XW-1:0] XLAST = XW'(HDISP - 1);
    localparam logic [YW-1:0] YLAST = YW'(VDISP - 1);

    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;

    // Decode the position of the beat about to be emitted
    always_comb begin
        at_origin = (x_q == '0) && (y_q == '0);
        at_eol    = (x_q == XLAST);
        at_eof    = at_eol && (y_q == YLAST);
    end

    // Advance raster position, wrapping x at line end and y at frame end
    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (clr) begin
            x_d = '0;
            y_d = '0;
        end else if (adv) begin
            if (at_eol) begin
                x_d = '0;
                y_d = at_eof ? '0 : y_q + YW'(1);
            end else begin
                x_d = x_q + XW'(1);
            end
        end
    end

    // Position registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            x_q <= '0;
            y_q <= '0;
        end else begin
            x_q <= x_d;
            y_q <= y_d;
        end
    end

endmodule

// File: rtl/dlsc_mt9v032_aligner.sv
// Lockstep aligner: waits for SOF on every enabled camera, then pops all lanes together and
// emits one wide beat per pixel with frame markers, a frame counter and a sticky sync error.
module dlsc_mt9v032_aligner
    import dlsc_mt9v032_pkg::*;
#(
    parameter int unsigned CAMERAS = 2,
    parameter int unsigned DATA    = 10,
    parameter int unsigned HDISP   = 752,
    parameter int unsigned VDISP   = 480,
    parameter int unsigned FCNT    = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                cfg_enable,
    input  logic [CAMERAS-1:0]  cfg_mask,
    dlsc_mt9v032_aligner_if.slave bus,
    output logic [FCNT-1:0]     frame_count,
    output logic                err_sync
);
    localparam int unsigned W = CAMERAS * DATA;

    state_t             state_q, state_d;
    logic [CAMERAS-1:0] mask_q, mask_d;
    logic               out_valid_q, out_valid_d;
    logic [W-1:0]       out_data_q, out_data_d;
    logic               out_sof_q, out_sof_d;
    logic               out_eol_q, out_eol_d;
    logic               out_eof_q, out_eof_d;
    logic [FCNT-1:0]    fcnt_q, fcnt_d;
    logic               err_q, err_d;

    logic [CAMERAS-1:0] in_ready;
    logic [CAMERAS-1:0] en_sof;
    logic [W-1:0]       lane_mask;
    logic               all_valid, all_sof, out_free, sof_bad;
    logic               adv, pos_clr;
    logic               at_origin, at_eol, at_eof;

    dlsc_mt9v032_aligner_pos #(
        .HDISP (HDISP),
        .VDISP (VDISP)
    ) u_pos (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (pos_clr),
        .adv       (adv),
        .at_origin (at_origin),
        .at_eol    (at_eol),
        .at_eof    (at_eof)
    );

    // Lane qualifiers; disabled lanes never block alignment
    always_comb begin
        lane_mask = '0;
        for (int unsigned j = 0; j < CAMERAS; j++) begin
            lane_mask[lane_sb_fix(j) +: DATA] = {DATA{mask_q[j]}};
        end
        en_sof    = bus.in_valid & bus.in_sof & mask_q;
        all_valid = &(bus.in_valid | ~mask_q);
        all_sof   = &(en_sof | ~mask_q);
        out_free  = bus.out_ready || !out_valid_q;
        // At the origin every enabled lane must carry SOF; elsewhere none may
        sof_bad   = at_origin ? (en_sof != mask_q) : (en_sof != '0);
    end

    function automatic int unsigned lane_sb_fix(input int unsigned j);
        return lane_lsb(j, DATA);
    endfunction

    // Next-state, pop and output-register logic
    always_comb begin
        state_d     = state_q;
        mask_d      = mask_q;
        in_ready    = '1;
        adv         = 1'b0;
        pos_clr     = 1'b0;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_sof_d   = out_sof_q;
        out_eol_d   = out_eol_q;
        out_eof_d   = out_eof_q;
        fcnt_d      = fcnt_q;
        err_d       = err_q;

        if (out_valid_q && bus.out_ready) begin
            out_valid_d = 1'b0;
        end

        unique case (state_q)
            ST_IDLE: begin
                if (cfg_enable) begin
                    mask_d  = cfg_mask;
                    state_d = ST_SYNC;
                end
            end
            ST_SYNC: begin
                // Drop everything ahead of SOF, hold SOF at the FIFO head
                in_ready = ~mask_q | (bus.in_valid & ~bus.in_sof);
                if (all_sof && (mask_q != '0)) begin
                    state_d = ST_RUN;
                    pos_clr = 1'b1;
                end
            end
            ST_RUN: begin
                in_ready = ~mask_q;
                if (all_valid && sof_bad) begin
                    err_d   = 1'b1;
                    state_d = ST_SYNC;
                end else if (all_valid && out_free) begin
                    adv         = 1'b1;
                    in_ready    = '1;
                    out_valid_d = 1'b1;
                    out_data_d  = bus.in_data & lane_mask;
                    out_sof_d   = at_origin;
                    out_eol_d   = at_eol;
                    out_eof_d   = at_eof;
                    if (at_eof) begin
                        fcnt_d = fcnt_q + FCNT'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Disable wins over everything except a pop already committed this cycle
        if (!cfg_enable) begin
            state_d = ST_IDLE;
            err_d   = 1'b0;
        end
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            mask_q      <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sof_q   <= 1'b0;
            out_eol_q   <= 1'b0;
            out_eof_q   <= 1'b0;
            fcnt_q      <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            mask_q      <= mask_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sof_q   <= out_sof_d;
            out_eol_q   <= out_eol_d;
            out_eof_q   <= out_eof_d;
            fcnt_q      <= fcnt_d;
            err_q       <= err_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_sof   = out_sof_q;
    assign bus.out_eol   = out_eol_q;
    assign bus.out_eof   = out_eof_q;
    assign frame_count   = fcnt_q;
    assign err_sync      = err_q;

endmodule

// File: tb/tb_dlsc_mt9v032_aligner.sv
// Bench for the frame aligner: queue-based camera sources, random backpressure and a
// frame-level expected-beat model.
module tb_dlsc_mt9v032_aligner;
    localparam int unsigned CAMERAS = 2;
    localparam int unsigned DATA    = 10;
    localparam int unsigned HDISP   = 4;
    localparam int unsigned VDISP   = 2;
    localparam int unsigned FCNT    = 2;
    localparam int unsigned FRAME   = HDISP * VDISP;
    localparam int unsigned W       = CAMERAS * DATA;

    typedef logic [W+2:0]  beat_t;   // {sof, eol, eof, data}
    typedef logic [DATA:0] cbeat_t;  // {sof, pixel}

    logic               clk = 1'b0;
    logic               rst_n;
    logic               cfg_enable;
    logic [CAMERAS-1:0] cfg_mask;
    logic [FCNT-1:0]    frame_count;
    logic               err_sync;

    dlsc_mt9v032_aligner_if #(.CAMERAS(CAMERAS), .DATA(DATA)) bus ();

    dlsc_mt9v032_aligner #(
        .CAMERAS (CAMERAS),
        .DATA    (DATA),
        .HDISP   (HDISP),
        .VDISP   (VDISP),
        .FCNT    (FCNT)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cfg_enable  (cfg_enable),
        .cfg_mask    (cfg_mask),
        .bus         (bus),
        .frame_count (frame_count),
        .err_sync    (err_sync)
    );

    always #5 clk = ~clk;

    cbeat_t      cq0[$];
    cbeat_t      cq1[$];
    beat_t       acc_q[$];
    beat_t       exp_q[$];
    bit          drive_en = 1'b0;
    int unsigned gap_pct = 0;
    int unsigned rdy_pct = 100;
    int          passed = 0;
    int          total = 0;
    int          stall_viol = 0;
    int          ready1_low = 0;
    bit          chk_ready1 = 1'b0;
    bit          stall_prev = 1'b0;
    beat_t       held;
    int          fc_exp = 0;

    // Camera sources and downstream sink; sampling 1 ns before the active edge
    always begin
        beat_t cur;
        @(negedge clk);
        if (drive_en && cq0.size() > 0 && $urandom_range(99) >= gap_pct) begin
            bus.in_valid[0]         = 1'b1;
            bus.in_sof[0]           = cq0[0][DATA];
            bus.in_data[DATA-1:0]   = cq0[0][DATA-1:0];
        end else begin
            bus.in_valid[0]         = 1'b0;
            bus.in_sof[0]           = 1'($urandom);
            bus.in_data[DATA-1:0]   = DATA'($urandom);
        end
        if (drive_en && cq1.size() > 0 && $urandom_range(99) >= gap_pct) begin
            bus.in_valid[1]         = 1'b1;
            bus.in_sof[1]           = cq1[0][DATA];
            bus.in_data[W-1:DATA]   = cq1[0][DATA-1:0];
        end else begin
            bus.in_valid[1]         = 1'b0;
            bus.in_sof[1]           = 1'($urandom);
            bus.in_data[W-1:DATA]   = DATA'($urandom);
        end
        bus.out_ready = ($urandom_range(99) < rdy_pct);
        #4;
        if (bus.in_valid[0] && bus.in_ready[0] && cq0.size() > 0) cq0.delete(0);
        if (bus.in_valid[1] && bus.in_ready[1] && cq1.size() > 0) cq1.delete(0);
        cur = {bus.out_sof, bus.out_eol, bus.out_eof, bus.out_data};
        if (stall_prev && cur !== held) stall_viol++;
        if (bus.out_valid && bus.out_ready) acc_q.push_back(cur);
        stall_prev = bus.out_valid && !bus.out_ready;
        held       = cur;
        if (chk_ready1 && bus.in_ready[1] !== 1'b1) ready1_low++;
    end

    // Expected wide beat for raster index p of a frame
    function automatic beat_t exp_beat(input int p, input logic [DATA-1:0] d1,
                                       input logic [DATA-1:0] d0);
        beat_t e;
        e[W-1:0] = {d1, d0};
        e[W+2]   = (p == 0);
        e[W+1]   = ((p % int'(HDISP)) == int'(HDISP) - 1);
        e[W]     = (p == int'(FRAME) - 1);
        return e;
    endfunction

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic flush();
        drive_en = 1'b0;
        rdy_pct  = 100;
        cycles(3);
        cq0.delete();
        cq1.delete();
        acc_q.delete();
        exp_q.delete();
    endtask

    // Queue g0/g1 non-SOF garbage beats then one frame per camera; lane1=0 means cam1 is ignored
    task automatic push_frame(input int g0, input int g1, input bit lane1);
        logic [DATA-1:0] d0, d1;
        for (int i = 0; i < g0; i++) cq0.push_back({1'b0, DATA'($urandom)});
        for (int i = 0; i < g1; i++) cq1.push_back({1'b0, DATA'($urandom)});
        for (int p = 0; p < int'(FRAME); p++) begin
            d0 = DATA'($urandom);
            d1 = DATA'($urandom);
            cq0.push_back({p == 0, d0});
            cq1.push_back({lane1 ? (p == 0) : 1'($urandom), d1});
            exp_q.push_back(exp_beat(p, lane1 ? d1 : '0, d0));
        end
    endtask

    task automatic wait_beats(input int n, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 2000; c++) begin
            @(negedge clk);
            if (acc_q.size() >= n) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n      = 1'b0;
        cfg_enable = 1'b1;
        cfg_mask   = 2'b11;
        drive_en   = 1'b0;
        rdy_pct    = 0;
        cycles(3);
        total++; if (bus.out_valid !== 1'b0) $display("FAIL rst_valid: got %b want 0", bus.out_valid); else passed++;
        total++; if (bus.out_data !== '0) $display("FAIL rst_data: got %h want 0", bus.out_data); else passed++;
        total++;
        if ({bus.out_sof, bus.out_eol, bus.out_eof} !== 3'b000)
            $display("FAIL rst_markers: got %b want 000", {bus.out_sof, bus.out_eol, bus.out_eof});
        else passed++;
        total++; if (frame_count !== '0) $display("FAIL rst_fcnt: got %0d want 0", frame_count); else passed++;
        total++; if (err_sync !== 1'b0) $display("FAIL rst_err: got %b want 0", err_sync); else passed++;
        total++; if (bus.in_ready !== 2'b11) $display("FAIL rst_ready: got %b want 11", bus.in_ready); else passed++;
        cfg_enable = 1'b0;
        rst_n      = 1'b1;
        cycles(2);
        total++; if (bus.in_ready !== 2'b11) $display("FAIL idle_ready: got %b want 11", bus.in_ready); else passed++;
    endtask

    task automatic test_sof_skew();
        bit ok;
        beat_t got;
        flush();
        cfg_mask   = 2'b11;
        cfg_enable = 1'b1;
        cycles(2);
        gap_pct = 0;
        rdy_pct = 100;
        push_frame(0, 3, 1'b1);
        drive_en = 1'b1;
        wait_beats(exp_q.size(), ok);
        total++; if (!ok) $display("FAIL skew_timeout: got %0d beats want %0d", acc_q.size(), exp_q.size()); else passed++;
        foreach (exp_q[i]) begin
            got = (i < acc_q.size()) ? acc_q[i] : 'x;
            total++; if (got !== exp_q[i]) $display("FAIL skew_beat%0d: got %h want %h", i, got, exp_q[i]); else passed++;
        end
        fc_exp = (fc_exp + 1) % 4;
        total++; if (frame_count !== FCNT'(fc_exp)) $display("FAIL skew_fcnt: got %0d want %0d", frame_count, fc_exp); else passed++;
        total++; if (err_sync !== 1'b0) $display("FAIL skew_err: got %b want 0", err_sync); else passed++;
    endtask

    task automatic test_random_stall();
        bit ok;
        beat_t got;
        flush();
        stall_viol = 0;
        gap_pct = 30;
        rdy_pct = 50;
        for (int f = 0; f < 3; f++) push_frame(0, 0, 1'b1);
        drive_en = 1'b1;
        wait_beats(exp_q.size(), ok);
        total++; if (!ok) $display("FAIL stall_timeout: got %0d beats want %0d", acc_q.size(), exp_q.size()); else passed++;
        foreach (exp_q[i]) begin
            got = (i < acc_q.size()) ? acc_q[i] : 'x;
            total++; if (got !== exp_q[i]) $display("FAIL stall_beat%0d: got %h want %h", i, got, exp_q[i]); else passed++;
        end
        fc_exp = (fc_exp + 3) % 4;
        total++; if (frame_count !== FCNT'(fc_exp)) $display("FAIL stall_fcnt: got %0d want %0d", frame_count, fc_exp); else passed++;
        total++; if (stall_viol !== 0) $display("FAIL stall_hold: got %0d changes want 0", stall_viol); else passed++;
    endtask

    task automatic test_sync_error();
        bit ok;
        beat_t got;
        logic [DATA-1:0] d0, d1;
        flush();
        gap_pct = 20;
        rdy_pct = 70;
        // cam1 restarts its frame at x=2,y=1 while cam0 is mid-frame
        for (int p = 0; p < int'(FRAME); p++) begin
            d0 = DATA'($urandom);
            d1 = DATA'($urandom);
            cq0.push_back({p == 0, d0});
            if (p < 6) begin
                cq1.push_back({p == 0, d1});
                exp_q.push_back(exp_beat(p, d1, d0));
            end
        end
        push_frame(0, 0, 1'b1);
        drive_en = 1'b1;
        wait_beats(exp_q.size(), ok);
        total++; if (!ok) $display("FAIL serr_timeout: got %0d beats want %0d", acc_q.size(), exp_q.size()); else passed++;
        foreach (exp_q[i]) begin
            got = (i < acc_q.size()) ? acc_q[i] : 'x;
            total++; if (got !== exp_q[i]) $display("FAIL serr_beat%0d: got %h want %h", i, got, exp_q[i]); else passed++;
        end
        fc_exp = (fc_exp + 1) % 4;
        total++; if (frame_count !== FCNT'(fc_exp)) $display("FAIL serr_fcnt: got %0d want %0d", frame_count, fc_exp); else passed++;
        total++; if (err_sync !== 1'b1) $display("FAIL serr_flag: got %b want 1", err_sync); else passed++;
    endtask

    task automatic test_mask();
        bit ok;
        beat_t got;
        flush();
        cfg_enable = 1'b0;
        cycles(1);
        total++; if (err_sync !== 1'b0) $display("FAIL mask_errclr: got %b want 0", err_sync); else passed++;
        total++; if (frame_count !== FCNT'(fc_exp)) $display("FAIL mask_fkeep: got %0d want %0d", frame_count, fc_exp); else passed++;
        cfg_mask   = 2'b01;
        cfg_enable = 1'b1;
        cycles(2);
        ready1_low = 0;
        chk_ready1 = 1'b1;
        gap_pct = 25;
        rdy_pct = 60;
        push_frame(0, 0, 1'b0);
        push_frame(0, 3, 1'b0);
        drive_en = 1'b1;
        wait_beats(exp_q.size(), ok);
        chk_ready1 = 1'b0;
        total++; if (!ok) $display("FAIL mask_timeout: got %0d beats want %0d", acc_q.size(), exp_q.size()); else passed++;
        foreach (exp_q[i]) begin
            got = (i < acc_q.size()) ? acc_q[i] : 'x;
            total++; if (got !== exp_q[i]) $display("FAIL mask_beat%0d: got %h want %h", i, got, exp_q[i]); else passed++;
        end
        fc_exp = (fc_exp + 2) % 4;
        total++; if (frame_count !== FCNT'(fc_exp)) $display("FAIL mask_fcnt: got %0d want %0d", frame_count, fc_exp); else passed++;
        total++; if (ready1_low !== 0) $display("FAIL mask_ready1: got %0d low cycles want 0", ready1_low); else passed++;
    endtask

    task automatic test_frame_wrap();
        bit ok;
        beat_t got;
        flush();
        rst_n = 1'b0;
        cycles(2);
        rst_n      = 1'b1;
        fc_exp     = 0;
        cfg_mask   = 2'b11;
        cfg_enable = 1'b1;
        cycles(2);
        gap_pct  = 10;
        rdy_pct  = 80;
        drive_en = 1'b1;
        for (int k = 0; k < 5; k++) begin
            acc_q.delete();
            exp_q.delete();
            push_frame(0, 0, 1'b1);
            wait_beats(exp_q.size(), ok);
            total++; if (!ok) $display("FAIL wrap%0d_timeout: got %0d beats want %0d", k, acc_q.size(), exp_q.size()); else passed++;
            foreach (exp_q[i]) begin
                got = (i < acc_q.size()) ? acc_q[i] : 'x;
                total++; if (got !== exp_q[i]) $display("FAIL wrap%0d_beat%0d: got %h want %h", k, i, got, exp_q[i]); else passed++;
            end
            fc_exp = (fc_exp + 1) % 4;
            total++; if (frame_count !== FCNT'(fc_exp)) $display("FAIL wrap%0d_fcnt: got %0d want %0d", k, frame_count, fc_exp); else passed++;
        end
    endtask

    task automatic test_reset_midframe();
        bit ok;
        beat_t got;
        flush();
        gap_pct = 0;
        rdy_pct = 100;
        push_frame(0, 0, 1'b1);
        drive_en = 1'b1;
        wait_beats(5, ok);
        total++; if (!ok) $display("FAIL mid_progress: got %0d beats want 5", acc_q.size()); else passed++;
        rst_n = 1'b0;
        cycles(1);
        total++; if (bus.out_valid !== 1'b0) $display("FAIL mid_rst_valid: got %b want 0", bus.out_valid); else passed++;
        total++; if (bus.out_data !== '0) $display("FAIL mid_rst_data: got %h want 0", bus.out_data); else passed++;
        total++;
        if ({bus.out_sof, bus.out_eol, bus.out_eof} !== 3'b000)
            $display("FAIL mid_rst_markers: got %b want 000", {bus.out_sof, bus.out_eol, bus.out_eof});
        else passed++;
        total++; if (frame_count !== '0) $display("FAIL mid_rst_fcnt: got %0d want 0", frame_count); else passed++;
        total++; if (bus.in_ready !== 2'b11) $display("FAIL mid_rst_ready: got %b want 11", bus.in_ready); else passed++;
        flush();
        rst_n  = 1'b1;
        fc_exp = 0;
        cycles(2);
        push_frame(0, 0, 1'b1);
        drive_en = 1'b1;
        wait_beats(exp_q.size(), ok);
        total++; if (!ok) $display("FAIL resync_timeout: got %0d beats want %0d", acc_q.size(), exp_q.size()); else passed++;
        foreach (exp_q[i]) begin
            got = (i < acc_q.size()) ? acc_q[i] : 'x;
            total++; if (got !== exp_q[i]) $display("FAIL resync_beat%0d: got %h want %h", i, got, exp_q[i]); else passed++;
        end
        fc_exp = 1;
        total++; if (frame_count !== FCNT'(fc_exp)) $display("FAIL resync_fcnt: got %0d want %0d", frame_count, fc_exp); else passed++;

        // Disable mid-frame: partial frame abandoned, counter kept
        flush();
        push_frame(0, 0, 1'b1);
        drive_en = 1'b1;
        wait_beats(3, ok);
        total++; if (!ok) $display("FAIL dis_progress: got %0d beats want 3", acc_q.size()); else passed++;
        cfg_enable = 1'b0;
        cycles(1);
        total++; if (bus.in_ready !== 2'b11) $display("FAIL dis_ready: got %b want 11", bus.in_ready); else passed++;
        total++; if (err_sync !== 1'b0) $display("FAIL dis_err: got %b want 0", err_sync); else passed++;
        total++; if (frame_count !== FCNT'(fc_exp)) $display("FAIL dis_fkeep: got %0d want %0d", frame_count, fc_exp); else passed++;
        flush();
        total++; if (bus.out_valid !== 1'b0) $display("FAIL dis_drain: got %b want 0", bus.out_valid); else passed++;
        cfg_enable = 1'b1;
        cycles(2);
        push_frame(0, 0, 1'b1);
        drive_en = 1'b1;
        wait_beats(exp_q.size(), ok);
        total++; if (!ok) $display("FAIL reen_timeout: got %0d beats want %0d", acc_q.size(), exp_q.size()); else passed++;
        foreach (exp_q[i]) begin
            got = (i < acc_q.size()) ? acc_q[i] : 'x;
            total++; if (got !== exp_q[i]) $display("FAIL reen_beat%0d: got %h want %h", i, got, exp_q[i]); else passed++;
        end
        fc_exp = 2;
        total++; if (frame_count !== FCNT'(fc_exp)) $display("FAIL reen_fcnt: got %0d want %0d", frame_count, fc_exp); else passed++;
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: got no finish want finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_sof_skew();
        test_random_stall();
        test_sync_error();
        test_mask();
        test_frame_wrap();
        test_reset_midframe();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
